// File: rtl/keypad_pkg.sv
// Shared keypad definitions: emulator FSM states, bounce LFSR constants and key-code decode helpers.
// Latency: none (types and pure functions); backpressure: n/a.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_IN,
        HOLD,
        BOUNCE_OUT,
        GAP
    } kp_state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Key code layout is {row, col}; the scanner decodes with the same helpers.
    function automatic logic [1:0] key_row(input logic [3:0] code);
        return code[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] code);
        return code[1:0];
    endfunction

endpackage

// File: rtl/hex_keypad_emulator_if.sv
// Key-press command handshake plus the column-drive / row-sense wires of a 4x4 keypad.
// Latency: n/a (wiring only); backpressure: key_ready gates key_valid.
interface hex_keypad_emulator_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] Col;
    logic [3:0] Row;
    logic       S_Row;
    logic       busy;
    logic       done;

    modport master (
        output key_code, key_valid, Col,
        input  key_ready, Row, S_Row, busy, done
    );

    modport slave (
        input  key_code, key_valid, Col,
        output key_ready, Row, S_Row, busy, done
    );
endinterface

// File: rtl/keypad_bounce_lfsr.sv
// Contact-chatter source: 8-bit Galois LFSR that steps only while advance is high.
// Latency: bounce_bit reflects the current state, updates one cycle after advance; backpressure: none.
module keypad_bounce_lfsr
    import keypad_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic advance,
    output logic bounce_bit
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (advance) begin
            lfsr_q <= lfsr_q[0] ? ({1'b0, lfsr_q[7:1]} ^ LFSR_TAPS) : {1'b0, lfsr_q[7:1]};
        end
    end

    assign bounce_bit = lfsr_q[0];

endmodule

// File: rtl/hex_keypad_emulator.sv
// Passive 4x4 keypad model: closes one switch per command with chatter; Row is combinational from Col.
// Latency: Row 0 cycles from Col, S_Row 1 cycle; backpressure: key_ready low for the whole press sequence.
module hex_keypad_emulator
    import keypad_pkg::*;
#(
    parameter int BOUNCE_CYCLES = 8,
    parameter int HOLD_CYCLES   = 64,
    parameter int GAP_CYCLES    = 16,
    parameter int CNT_W         = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    hex_keypad_emulator_if.slave  kp
);

    localparam bit               HAS_BOUNCE = (BOUNCE_CYCLES != 0);
    localparam logic [CNT_W-1:0] B_LOAD     = CNT_W'(BOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] H_LOAD     = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] G_LOAD     = CNT_W'(GAP_CYCLES - 1);

    kp_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_q, key_d;
    logic             done_q, done_d;
    logic             s_row_q;
    logic             ready;
    logic             advance;
    logic             bounce_bit;
    logic             contact;
    logic [3:0]       row_dat;

    keypad_bounce_lfsr u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .advance    (advance),
        .bounce_bit (bounce_bit)
    );

    assign ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        done_d  = 1'b0;
        advance = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (kp.key_valid && ready) begin
                    key_d = kp.key_code;
                    if (HAS_BOUNCE) begin
                        state_d = BOUNCE_IN;
                        cnt_d   = B_LOAD;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = H_LOAD;
                    end
                end
            end
            BOUNCE_IN: begin
                advance = 1'b1;
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    cnt_d   = H_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    if (HAS_BOUNCE) begin
                        state_d = BOUNCE_OUT;
                        cnt_d   = B_LOAD;
                    end else begin
                        state_d = GAP;
                        cnt_d   = G_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BOUNCE_OUT: begin
                advance = 1'b1;
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = G_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row depends only on async-reset state and Col, so it drops as soon as reset asserts.
    always_comb begin
        contact = 1'b0;
        case (state_q)
            HOLD:                  contact = 1'b1;
            BOUNCE_IN, BOUNCE_OUT: contact = bounce_bit;
            default:               contact = 1'b0;
        endcase
        row_dat = '0;
        row_dat[key_row(key_q)] = contact & kp.Col[key_col(key_q)];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            key_q   <= '0;
            done_q  <= 1'b0;
            s_row_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            done_q  <= done_d;
            s_row_q <= |row_dat;
        end
    end

    assign kp.key_ready = ready;
    assign kp.busy      = !ready;
    assign kp.done      = done_q;
    assign kp.S_Row     = s_row_q;
    assign kp.Row       = row_dat;

endmodule

// File: tb/tb_hex_keypad_emulator.sv
// Bench for hex_keypad_emulator: a short-timing instance driven from a vector table and hand sequences,
// and a default-timing instance checked every cycle against a phase/LFSR reference model.
module tb_hex_keypad_emulator;
    import keypad_pkg::*;

    localparam int B   = 8;
    localparam int H   = 64;
    localparam int G   = 16;
    localparam int TOT = 2 * B + H + G + 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    hex_keypad_emulator_if ifs ();
    hex_keypad_emulator_if ifd ();

    hex_keypad_emulator #(.BOUNCE_CYCLES(0), .HOLD_CYCLES(4), .GAP_CYCLES(2), .CNT_W(8)) dut_s (
        .clock (clock),
        .reset (reset),
        .kp    (ifs)
    );

    hex_keypad_emulator dut_d (
        .clock (clock),
        .reset (reset),
        .kp    (ifd)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_lfsr;

    typedef struct {
        logic [3:0] col;
        logic [3:0] row;
        logic       srow;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[7];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic [7:0] sh;
        sh = v >> 1;
        return v[0] ? (sh ^ 8'hB8) : sh;
    endfunction

    // Press key on the default instance and check cycles 1..stop_k after the accept edge.
    task automatic run_d(input logic [3:0] key, input bit rnd, input int stop_k);
        logic [3:0] er;
        logic       prev;
        logic       c;
        bit         bnc;
        ifd.key_code  = key;
        ifd.key_valid = 1'b1;
        prev = 1'b0;
        tick();
        ifd.key_valid = 1'b0;
        ifd.key_code  = 4'($urandom);
        for (int k = 1; k <= stop_k; k++) begin
            ifd.Col = rnd ? 4'($urandom) : 4'hF;
            #1;
            bnc = (k <= B) || (k > B + H && k <= 2 * B + H);
            c   = bnc ? m_lfsr[0] : (k > B && k <= B + H);
            er  = 4'h0;
            er[key[3:2]] = c & ifd.Col[key[1:0]];
            chk("d_row",  8'(ifd.Row),   8'(er));
            chk("d_srow", 8'(ifd.S_Row), 8'(prev));
            chk("d_busy", 8'(ifd.busy),  8'(k < TOT));
            chk("d_done", 8'(ifd.done),  8'(k == TOT));
            prev = |er;
            if (bnc) m_lfsr = lfsr_next(m_lfsr);
            if (k < stop_k) tick();
        end
    endtask

    initial begin
        logic [3:0] rep;
        logic       found;

        tbl[0] = '{4'b0100, 4'b0010, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{4'b1111, 4'b0010, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{4'b1111, 4'b0010, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1};

        ifs.key_code = 4'h0; ifs.key_valid = 1'b0; ifs.Col = 4'hF;
        ifd.key_code = 4'h0; ifd.key_valid = 1'b0; ifd.Col = 4'hF;
        m_lfsr = 8'hA5;
        reset  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", 8'(ifd.key_ready), 8'h1);
        chk("rst_busy",  8'(ifd.busy),      8'h0);
        chk("rst_done",  8'(ifd.done),      8'h0);
        chk("rst_row",   8'(ifd.Row),       8'h0);
        chk("rst_srow",  8'(ifd.S_Row),     8'h0);
        chk("rst_s_row", 8'(ifs.Row),       8'h0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        // Short instance: key 6 (row 1, col 2) through HOLD, GAP and done.
        ifs.key_code = 4'h6; ifs.key_valid = 1'b1;
        tick();
        ifs.key_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ifs.Col = tbl[i].col;
            #1;
            chk("tbl_row",  8'(ifs.Row),   8'(tbl[i].row));
            chk("tbl_srow", 8'(ifs.S_Row), 8'(tbl[i].srow));
            chk("tbl_busy", 8'(ifs.busy),  8'(tbl[i].busy));
            chk("tbl_done", 8'(ifs.done),  8'(tbl[i].done));
            if (i < 6) tick();
        end

        // Requests while busy are dropped; one held into the done cycle is taken there.
        ifs.key_code = 4'h6; ifs.key_valid = 1'b1;
        tick();
        ifs.key_code = 4'h3;
        ifs.Col = 4'hF;
        for (int k = 1; k <= 6; k++) begin
            #1;
            chk("ign_row",   8'(ifs.Row),       (k <= 4) ? 8'h2 : 8'h0);
            chk("ign_ready", 8'(ifs.key_ready), 8'h0);
            tick();
        end
        chk("ign_done",  8'(ifs.done),      8'h1);
        chk("ign_ready", 8'(ifs.key_ready), 8'h1);
        tick();
        ifs.key_valid = 1'b0;
        #1;
        chk("b2b_row",  8'(ifs.Row),  8'h1);
        chk("b2b_busy", 8'(ifs.busy), 8'h1);
        repeat (6) tick();
        chk("b2b_done", 8'(ifs.done), 8'h1);

        // Default instance: fixed Col first, then random keys/Col back-to-back.
        run_d(4'hF, 1'b0, TOT);
        for (int n = 0; n < 3; n++) run_d(4'($urandom), 1'b1, TOT);

        // Reset at HOLD cycle 30, then the bounce pattern must restart from the seed.
        run_d(4'h5, 1'b1, B + 30);
        ifd.Col = 4'hF;
        #1;
        chk("mid_row_pre", 8'(ifd.Row), 8'h2);
        reset = 1'b1;
        #1;
        chk("mid_row",   8'(ifd.Row),       8'h0);
        chk("mid_srow",  8'(ifd.S_Row),     8'h0);
        chk("mid_busy",  8'(ifd.busy),      8'h0);
        chk("mid_ready", 8'(ifd.key_ready), 8'h1);
        #1;
        reset  = 1'b0;
        m_lfsr = 8'hA5;
        tick();
        run_d(4'hF, 1'b0, TOT);

        // Closed-loop scan of all codes on the short instance.
        for (int code = 0; code < 16; code++) begin
            ifs.key_code = 4'(code); ifs.key_valid = 1'b1;
            tick();
            ifs.key_valid = 1'b0;
            found = 1'b0;
            rep   = 4'h0;
            for (int k = 1; k <= 4; k++) begin
                ifs.Col = 4'(1 << (k - 1));
                #1;
                for (int r = 0; r < 4; r++) begin
                    if (ifs.Row[r]) begin
                        found = 1'b1;
                        rep   = 4'(4 * r + k - 1);
                    end
                end
                tick();
            end
            chk("scan_valid", 8'(found), 8'h1);
            chk("scan_code",  8'(rep),   8'(code));
            ifs.Col = 4'hF;
            for (int k = 5; k <= 6; k++) begin
                #1;
                chk("scan_gap_row", 8'(ifs.Row), 8'h0);
                tick();
            end
            chk("scan_done", 8'(ifs.done), 8'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_keypad_emulator.md
# hex_keypad_emulator

Synthesizable model of the 4x4 hex keypad, the passive side of the column-drive / row-sense interface used by our keypad scanner. It accepts key-press commands through a valid/ready handshake, closes the matching switch for a programmed time with LFSR-generated contact bounce on press and release, and drives Row combinationally from the scanner's Col. It also produces the registered S_Row strobe. It is used for hardware-in-loop and FPGA self-test of the scanner, with no physical keypad attached.

## Interface
- BOUNCE_CYCLES, 8: chatter cycles on press and on release; 0 disables bounce.
- HOLD_CYCLES, 64: cycles the contact is solidly closed; must be ≥1.
- GAP_CYCLES, 16: released cycles before the next key is accepted; must be ≥1.
- CNT_W, 8: phase counter width; every cycle parameter must be ≤ 2^CNT_W.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- key_code  in  4  key to press; row = key_code[3:2], col = key_code[1:0] (value = 4·row + col).
- key_valid  in  1  press request.
- key_ready  out  1  high only in IDLE.
- Col  in  4  column drive from the scanner.
- Row  out  4  row sense back to the scanner.
- S_Row  out  1  registered OR of Row.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a press/release sequence completes.

## Operation
- States: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP.
- IDLE → accept a command when key_valid & key_ready. Latch key_code and load the counter with the first phase length − 1. Next state is BOUNCE_IN, or HOLD if BOUNCE_CYCLES = 0.
- Each phase counts down, then advances on count = 0: BOUNCE_IN → HOLD → BOUNCE_OUT (skipped if BOUNCE_CYCLES = 0) → GAP → IDLE.
- Contact: 0 in IDLE and GAP; 1 in HOLD; lfsr[0] in BOUNCE_IN and BOUNCE_OUT.
- Row[r_latched] = contact & Col[c_latched]. All other Row bits are 0. Row is combinational from Col and registered state; there is no Col→Row register, so a scanner sees the same-cycle response a real keypad gives.
- LFSR: 8-bit Galois, taps 8'hB8, seed 8'hA5. It advances only in bounce states and keeps its value across presses, so the bounce pattern is deterministic from reset.
- S_Row <= |Row on every clock edge.
- done is registered and is high in the first IDLE cycle after GAP. A new key may be accepted in that same cycle.
- key_valid while busy is ignored, not queued. key_code is sampled only on the accept edge.
- Reset, including mid-sequence:
  - state goes to IDLE and the counter to 0;
  - LFSR reloads to 8'hA5;
  - Row, S_Row, done and busy go to 0, and key_ready goes to 1;
  - Row clears asynchronously with reset.

## Timing
- Accept edge at cycle T. Phase occupancy:
  - BOUNCE_IN: cycles T+1 … T+B (B = BOUNCE_CYCLES);
  - HOLD: the next HOLD_CYCLES cycles;
  - BOUNCE_OUT: the next B cycles;
  - GAP: the next GAP_CYCLES cycles.
- done fires at T + 2B + HOLD_CYCLES + GAP_CYCLES + 1.
- Throughput with back-to-back commands: one key per 2B + HOLD_CYCLES + GAP_CYCLES + 1 cycles.
- Row responds to a Col change in 0 cycles. S_Row lags Row by 1 cycle.
- Defaults: a command accepted at T=0 has HOLD at cycles 9–72 and done at cycle 97.

## Structure
- Shared package keypad_pkg holds:
  - the state enum;
  - LFSR_SEED (8'hA5) and LFSR_TAPS (8'hB8);
  - the helper functions key_row(code) and key_col(code).
- The scanner reuses key_row and key_col for its own decode.
- One sub-module, keypad_bounce_lfsr, with ports clock, reset, advance and bit. The FSM, counter, Row logic and S_Row register stay in the top module.

## Test plan
- Press 0x6 with B=0, H=4, G=2. During HOLD: Col=4'b0100 → Row=4'b0010; Col=4'b0001 → Row=0; Col=4'hF → Row=4'b0010. S_Row=1 one cycle later. done fires at cycle T+7.
- Defaults, press 0xF with Col held at 4'hF. Row[3] toggles per LFSR bit0 for 8 cycles starting from seed 8'hA5, is steady 1 for 64 cycles, chatters for 8, is 0 for 16, then done fires.
- Assert key_valid=1 with key_code=0x3 while busy. The command is not accepted and the latched key stays unchanged. key_valid held across the done cycle is accepted in that cycle.
- Apply reset at cycle 30 of HOLD. Row, S_Row and busy are 0 within the reset cycle. The next press shows the bounce pattern restarting from seed 8'hA5.
- Closed loop with the scanner: sweep all 16 codes. The scanner reports Code equal to the pressed key with Valid high, and nothing is reported during GAP.
